// File: rtl/seg7_bcd_counter_if.sv
// Bundle of the counter's strobe inputs and display/value outputs.
// The master side (the upstream logic or a bench) drives the strobes.
// The slave side (the counter) drives the count and the display pins.
interface seg7_bcd_counter_if;
  logic        count_en;
  logic        clear;
  logic [31:0] bcd_value;
  logic        overflow;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;

  modport master (
    output count_en, clear,
    input  bcd_value, overflow, seg_n, dp_n, an_n
  );

  modport slave (
    input  count_en, clear,
    output bcd_value, overflow, seg_n, dp_n, an_n
  );
endinterface

// File: rtl/seg7_bcd_counter.sv
// Eight-digit packed-BCD event counter with a sticky overflow flag.
// It drives a time-multiplexed common-anode seven-segment display.
// The display outputs are registered from the current count and scan index,
// so the anode and segment values always change on the same edge.
module seg7_bcd_counter #(
  parameter int DIGIT_PERIOD = 100000,
  parameter bit BLANK_ZEROS  = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg7_bcd_counter_if.slave bus
);

  localparam int            TW        = $clog2(DIGIT_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_PERIOD - 1);

  // Active-low segment pattern for one BCD digit; codes A-F light nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [31:0]   bcd_q, bcd_d;
  logic          overflow_q, overflow_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic          carry_s;
  logic [7:0]    zero_from_s;
  logic [3:0]    nibble_s;
  logic          blank_s;

  // Next count: clear has priority; an increment ripples the carry through all digits.
  always_comb begin
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    carry_s    = 1'b0;
    if (bus.clear) begin
      bcd_d      = 32'h0000_0000;
      overflow_d = 1'b0;
    end else if (bus.count_en) begin
      carry_s = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (carry_s) begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry_s         = 1'b0;
          end
        end else begin
          bcd_d[4*i +: 4] = bcd_q[4*i +: 4];
        end
      end
      if (carry_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
    end
  end

  // Refresh timer: the digit index advances on the cycle the tick counter wraps.
  always_comb begin
    tick_d = tick_q;
    idx_d  = idx_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      tick_d = tick_q + TW'(1);
      idx_d  = idx_q;
    end
  end

  // Display decode for the digit being scanned, including leading-zero blanking.
  always_comb begin
    zero_from_s    = 8'h00;
    zero_from_s[7] = (bcd_q[31:28] == 4'd0);
    for (int i = 6; i >= 0; i--) begin
      zero_from_s[i] = zero_from_s[i+1] & (bcd_q[4*i +: 4] == 4'd0);
    end
    nibble_s = bcd_q[{idx_q, 2'b00} +: 4];
    blank_s  = BLANK_ZEROS && (idx_q != 3'd0) && zero_from_s[idx_q];
    if (blank_s) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = seg_decode(nibble_s);
    end
    an_d = ~(8'h01 << idx_q);
    if ((idx_q == 3'd7) && overflow_q) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // State and registered display outputs, all returning to idle on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q      <= 32'h0000_0000;
      overflow_q <= 1'b0;
      tick_q     <= '0;
      idx_q      <= 3'd0;
      seg_q      <= 7'h7F;
      an_q       <= 8'hFF;
      dp_q       <= 1'b1;
    end else begin
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.bcd_value = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.seg_n     = seg_q;
  assign bus.dp_n      = dp_q;
  assign bus.an_n      = an_q;

endmodule
